// File: rtl/keypad_entry.sv
// keypad_entry: 4x4 matrix keypad scanner with debounce and an 8-digit entry buffer.
//
// Ports:
//   clock        system clock, all state changes on the rising edge
//   reset        synchronous, active-high reset
//   row_n[3:0]   keypad rows, active-low, pulled up, asynchronous to clock
//   col_n[3:0]   keypad column drive, active-low, exactly one bit low
//   key_valid    one-cycle pulse for each accepted key press
//   key_code     code of the most recently accepted key
//   digits       entered digits, first digit in [3:0], eighth in [31:28]
//   digit_count  number of stored digits, 0..8
//   buf_full     high when eight digits are stored
//
// Parameters:
//   SCAN_DIV        clock cycles each column is driven (>= 4)
//   DEBOUNCE_SCANS  consecutive identical full scans to accept a press or release (>= 1)

module keypad_entry #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [31:0] digits,
  output logic [3:0]  digit_count,
  output logic        buf_full
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;

  state_t             state, state_next;
  logic [3:0]         row_meta, row_sync;
  logic [DIV_W-1:0]   div_cnt;
  logic [1:0]         col_idx;
  logic               sample, scan_end;
  logic [1:0]         acc_hits, col_hits, tot_hits;
  logic [3:0]         acc_code, col_code, tot_code;
  logic [2:0]         hit_sum;
  logic               scan_single, scan_none;
  logic [CNT_W-1:0]   match_cnt, match_next;
  logic [CNT_W-1:0]   release_cnt, release_next;
  logic [3:0]         candidate, cand_next;
  logic               accept;
  logic [2:0]         wr_idx, bs_idx;

  // Key code lookup indexed by {row, col}.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Two-flop synchronizer; idles at "no row pulled low".
  always_ff @(posedge clock) begin
    if (reset) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row_n;
      row_sync <= row_meta;
    end
  end

  // Column divider: sample happens on the final cycle of each column period.
  assign sample   = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign scan_end = sample && (col_idx == 2'd3);

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt <= '0;
      col_idx <= 2'd0;
    end else if (sample) begin
      div_cnt <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign col_n = ~(4'b0001 << col_idx);

  // Keys seen in the current column; hit count saturates at 2 (multi).
  always_comb begin
    col_hits = 2'd0;
    col_code = 4'h0;
    for (int r = 0; r < 4; r++) begin
      if (!row_sync[r]) begin
        if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
        col_code = key_map(2'(r), col_idx);
      end
    end
  end

  // Merge with the earlier columns of this scan; the code only matters when one key is seen.
  always_comb begin
    hit_sum  = {1'b0, acc_hits} + {1'b0, col_hits};
    tot_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    tot_code = (acc_hits != 2'd0) ? acc_code : col_code;
  end

  assign scan_single = scan_end && (tot_hits == 2'd1);
  assign scan_none   = scan_end && (tot_hits == 2'd0);

  // Per-scan accumulator, cleared when the column-3 sample closes the scan.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_hits <= 2'd0;
      acc_code <= 4'h0;
    end else if (sample) begin
      if (col_idx == 2'd3) begin
        acc_hits <= 2'd0;
        acc_code <= 4'h0;
      end else begin
        acc_hits <= tot_hits;
        acc_code <= tot_code;
      end
    end
  end

  // FSM state register with its debounce counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      match_cnt   <= '0;
      release_cnt <= '0;
      candidate   <= 4'h0;
    end else begin
      state       <= state_next;
      match_cnt   <= match_next;
      release_cnt <= release_next;
      candidate   <= cand_next;
    end
  end

  // FSM next state; everything moves only at scan end.
  always_comb begin
    state_next   = state;
    match_next   = match_cnt;
    release_next = release_cnt;
    cand_next    = candidate;
    if (scan_end) begin
      case (state)
        IDLE: begin
          if (scan_single) begin
            cand_next = tot_code;
            if (DEBOUNCE_SCANS == 1) begin
              state_next   = HELD;
              release_next = '0;
            end else begin
              state_next = DEBOUNCE;
              match_next = CNT_W'(1);
            end
          end
        end
        DEBOUNCE: begin
          if (scan_single && (tot_code == candidate)) begin
            if (match_cnt + CNT_W'(1) == CNT_W'(DEBOUNCE_SCANS)) begin
              state_next   = HELD;
              match_next   = '0;
              release_next = '0;
            end else begin
              match_next = match_cnt + CNT_W'(1);
            end
          end else begin
            state_next = IDLE;
            match_next = '0;
          end
        end
        HELD: begin
          if (scan_none) begin
            if (release_cnt + CNT_W'(1) == CNT_W'(DEBOUNCE_SCANS)) begin
              state_next   = IDLE;
              release_next = '0;
            end else begin
              release_next = release_cnt + CNT_W'(1);
            end
          end else begin
            release_next = '0;
          end
        end
        default: begin
          state_next   = IDLE;
          match_next   = '0;
          release_next = '0;
        end
      endcase
    end
  end

  // FSM output: a press is accepted exactly when we are about to enter HELD.
  always_comb begin
    accept = (state != HELD) && (state_next == HELD);
  end

  assign wr_idx   = digit_count[2:0];
  assign bs_idx   = 3'(digit_count - 4'd1);
  assign buf_full = (digit_count == 4'd8);

  // Key output and digit buffer; vacated nibbles are zeroed so unused slots read 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      key_valid   <= 1'b0;
      key_code    <= 4'h0;
      digits      <= 32'h0;
      digit_count <= 4'd0;
    end else begin
      key_valid <= accept;
      if (accept) begin
        key_code <= tot_code;
        if (tot_code <= 4'd9) begin
          if (digit_count != 4'd8) begin
            digits[{wr_idx, 2'b00} +: 4] <= tot_code;
            digit_count                  <= digit_count + 4'd1;
          end
        end else if (tot_code == 4'hA) begin
          if (digit_count != 4'd0) begin
            digits[{bs_idx, 2'b00} +: 4] <= 4'h0;
            digit_count                  <= digit_count - 4'd1;
          end
        end else if (tot_code == 4'hC) begin
          digits      <= 32'h0;
          digit_count <= 4'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: randomized and directed bench for keypad_entry with SCAN_DIV = 4 and
// DEBOUNCE_SCANS = 2. A physical keypad model drives row_n from a 16-bit key mask
// (bit r*4+c = key at row r, column c). The key mask changes only at scan boundaries,
// and a per-scan reference model predicts the accepted keys and the digit buffer.

module tb_keypad_entry;

  localparam int SD = 4;
  localparam int DS = 2;
  localparam int SCAN_CYCLES = 4 * SD;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [31:0] digits;
  logic [3:0]  digit_count;
  logic        buf_full;
  logic [15:0] key_mask = 16'h0;

  int checks = 0;
  int errors = 0;
  int pulses_seen = 0;

  // Reference model state
  bit         exp_valid = 1'b0;
  logic [3:0] exp_code = 4'h0;
  int         entered[$];
  bit         m_held = 1'b0;
  int         m_run_key = 0;
  int         m_run_len = 0;
  int         m_quiet = 0;

  int key_table [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clock       (clock),
    .reset       (reset),
    .row_n       (row_n),
    .col_n       (col_n),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .digits      (digits),
    .digit_count (digit_count),
    .buf_full    (buf_full)
  );

  always #5 clock = ~clock;

  // Keypad matrix: a pressed key shorts its row to its column when that column is driven low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_mask[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] maskFor(input int code);
    logic [15:0] m;
    m = 16'h0;
    for (int b = 0; b < 16; b++)
      if (key_table[b] == code) m[b] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] expDigits();
    logic [31:0] d;
    d = 32'h0;
    for (int i = 0; i < entered.size(); i++) d[i*4 +: 4] = 4'(entered[i]);
    return d;
  endfunction

  // Buffer effect of an accepted key, expressed as queue operations.
  task automatic modelAccept(input int code);
    exp_valid = 1'b1;
    exp_code  = 4'(code);
    if (code <= 9) begin
      if (entered.size() < 8) entered.push_back(code);
    end else if (code == 10) begin
      if (entered.size() > 0) void'(entered.pop_back());
    end else if (code == 12) begin
      entered.delete();
    end
  endtask

  // One scan's worth of debounce: a press needs DS identical single-key scans in a row
  // while released; a release needs DS empty scans in a row while held.
  task automatic modelScan(input logic [15:0] mask);
    int n;
    int code;
    n = $countones(mask);
    code = 0;
    for (int b = 0; b < 16; b++)
      if (mask[b]) code = key_table[b];
    if (!m_held) begin
      if (n == 1) begin
        if (m_run_len == 0) begin
          m_run_key = code;
          m_run_len = 1;
        end else if (code == m_run_key) begin
          m_run_len++;
        end else begin
          m_run_len = 0;
        end
        if (m_run_len == DS) begin
          modelAccept(code);
          m_held    = 1'b1;
          m_quiet   = 0;
          m_run_len = 0;
        end
      end else begin
        m_run_len = 0;
      end
    end else begin
      if (n == 0) begin
        m_quiet++;
        if (m_quiet == DS) begin
          m_held  = 1'b0;
          m_quiet = 0;
        end
      end else begin
        m_quiet = 0;
      end
    end
  endtask

  // Checks made at the first cycle of every scan, where any acceptance pulse shows up.
  task automatic checkScanStart();
    checkOutput("key_valid", key_valid, exp_valid);
    if (key_valid === 1'b1) pulses_seen++;
    checkOutput("key_code", key_code, exp_code);
    checkOutput("digits", digits, expDigits());
    checkOutput("digit_count", digit_count, entered.size());
    checkOutput("buf_full", buf_full, entered.size() == 8);
    checkOutput("col_n_start", col_n, 4'hE);
    exp_valid = 1'b0;
  endtask

  // Hold a key mask for one full scan, checking the column walk and the absence of
  // pulses mid-scan, then fold the scan into the model.
  task automatic applyStimulus(input logic [15:0] mask);
    logic [3:0] exp_col;
    checkScanStart();
    key_mask = mask;
    for (int i = 1; i < SCAN_CYCLES; i++) begin
      @(negedge clock);
      exp_col = ~(4'b0001 << (i / SD));
      checkOutput("col_n", col_n, exp_col);
      checkOutput("key_valid_mid", key_valid, 1'b0);
    end
    @(negedge clock);
    modelScan(mask);
  endtask

  // Reset for two edges, leaving the bench aligned on the first cycle of a fresh scan.
  task automatic applyReset(input bit check_first);
    if (check_first) checkScanStart();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset     = 1'b0;
    m_held    = 1'b0;
    m_run_len = 0;
    m_quiet   = 0;
    entered.delete();
    exp_code  = 4'h0;
    exp_valid = 1'b0;
  endtask

  task automatic pressKey(input int code, input int hold, input int rel);
    for (int i = 0; i < hold; i++) applyStimulus(maskFor(code));
    for (int i = 0; i < rel; i++) applyStimulus(16'h0);
  endtask

  // Directed scenarios first, then randomized presses, multi-key chords and resets.
  initial begin
    int p0;
    int kind;
    int b1;
    int b2;
    applyReset(1'b0);

    p0 = pulses_seen;
    pressKey(5, 10, 3);
    checkOutput("k5_pulses", pulses_seen - p0, 1);
    checkOutput("k5_digits", digits, 32'h00000005);

    applyReset(1'b1);
    pressKey(1, 3, 2);
    pressKey(2, 3, 2);
    pressKey(3, 3, 2);
    checkOutput("e123_digits", digits, 32'h00000321);
    pressKey(10, 3, 2);
    checkOutput("bksp_digits", digits, 32'h00000021);
    checkOutput("bksp_count", digit_count, 4'd2);
    pressKey(12, 3, 2);
    checkOutput("clear_digits", digits, 32'h0);

    for (int k = 1; k <= 8; k++) pressKey(k, 3, 2);
    checkOutput("full_digits", digits, 32'h87654321);
    checkOutput("full_flag", buf_full, 1'b1);
    p0 = pulses_seen;
    pressKey(9, 3, 2);
    checkOutput("ninth_pulses", pulses_seen - p0, 1);
    checkOutput("ninth_code", key_code, 4'h9);
    checkOutput("ninth_digits", digits, 32'h87654321);

    applyReset(1'b1);
    p0 = pulses_seen;
    pressKey(7, 1, 3);
    applyStimulus(maskFor(1) | maskFor(6));
    for (int i = 0; i < 9; i++) applyStimulus(maskFor(1) | maskFor(6));
    pressKey(0, 0, 3);
    checkOutput("glitch_multi_pulses", pulses_seen - p0, 0);

    p0 = pulses_seen;
    applyStimulus(maskFor(3));
    applyReset(1'b1);
    checkOutput("rst_db_pulses", pulses_seen - p0, 0);
    pressKey(3, 3, 3);
    checkOutput("rst_db_after", pulses_seen - p0, 1);
    checkOutput("rst_db_code", key_code, 4'h3);

    for (int n = 0; n < 50; n++) begin
      kind = $urandom_range(0, 19);
      if (kind < 13) begin
        pressKey($urandom_range(0, 15), $urandom_range(1, 4), $urandom_range(0, 3));
      end else if (kind < 16) begin
        b1 = $urandom_range(0, 15);
        b2 = (b1 + $urandom_range(1, 15)) % 16;
        for (int i = 0; i < $urandom_range(1, 3); i++)
          applyStimulus((16'h1 << b1) | (16'h1 << b2));
        pressKey(0, 0, $urandom_range(0, 2));
      end else if (kind < 19) begin
        applyStimulus(maskFor($urandom_range(0, 15)));
        pressKey($urandom_range(0, 15), $urandom_range(1, 3), $urandom_range(1, 3));
      end else begin
        applyReset(1'b1);
      end
    end
    pressKey(0, 0, 3);
    checkScanStart();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 Parameter SCAN_DIV, default 1000, clock cycles each keypad column is driven; legal range >= 4.
REQ-002 Parameter DEBOUNCE_SCANS, default 4, consecutive identical full scans needed to accept a press or a release; legal range >= 1.
REQ-003 clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 row_n  input  4  keypad row lines, active-low, externally pulled up, asynchronous to clock.
REQ-006 col_n  output 4  keypad column drive, active-low, exactly one bit low at all times.
REQ-007 key_valid  output 1  one-cycle pulse per accepted key press.
REQ-008 key_code  output 4  code of the most recently accepted key, held until the next accepted key.
REQ-009 digits  output 32  entered digit buffer, 8 nibbles; first entered digit in [3:0], second in [7:4], up to eighth in [31:28]; feeds the 8-digit display scanner.
REQ-010 digit_count  output 4  number of stored digits, 0..8.
REQ-011 buf_full  output 1  high when digit_count equals 8.

Function
REQ-012 row_n shall pass through a 2-flop synchronizer before any use.
REQ-013 Column index shall advance 0,1,2,3,0,... every SCAN_DIV cycles; col_n = 4'b1110, 4'b1101, 4'b1011, 4'b0111 for index 0..3.
REQ-014 Synchronized rows shall be sampled on the last cycle of each column period; a low row r in column c means key (r,c) is pressed.
REQ-015 Key map (row,col to code): row0 = 1,2,3,A; row1 = 4,5,6,B; row2 = 7,8,9,C; row3 = E(*),0,F(#),D.
REQ-016 A full scan ends at the column-3 sample; its result is NONE (no key), SINGLE(code) (exactly one key), or MULTI (two or more keys, any columns).
REQ-017 FSM states: IDLE, DEBOUNCE, HELD; all transitions occur only at scan end.
REQ-018 IDLE: SINGLE(k) -> DEBOUNCE, candidate = k, match count = 1; NONE or MULTI -> stay IDLE.
REQ-019 DEBOUNCE: SINGLE(candidate) increments match count; when match count reaches DEBOUNCE_SCANS -> accept and go HELD; any other result -> IDLE with no acceptance.
REQ-020 With DEBOUNCE_SCANS = 1, a SINGLE result in IDLE shall be accepted at that same scan end.
REQ-021 HELD: DEBOUNCE_SCANS consecutive NONE scans -> IDLE; any SINGLE or MULTI clears the release count; no auto-repeat.
REQ-022 On acceptance, key_valid, key_code, digits and digit_count shall all update in the cycle immediately after the scan-end sample (one-cycle latency).
REQ-023 Keys 0-9: if digit_count < 8, write code to nibble index digit_count and increment it; if digit_count = 8, leave buffer unchanged; key_valid still pulses.
REQ-024 Key A (backspace): if digit_count > 0, decrement it and zero the vacated nibble; if 0, no change.
REQ-025 Key C (clear): digits = 0, digit_count = 0.
REQ-026 Keys B, D, E, F: key_valid and key_code only; buffer unchanged.
REQ-027 Unused nibbles at or above digit_count shall always read 0.

Reset
REQ-028 While reset is high at a clock edge, the block shall load: col_n = 4'b1110, column index 0, divider 0, state IDLE, all debounce counts 0, key_valid = 0, key_code = 0, digits = 0, digit_count = 0, buf_full = 0, synchronizer flops = 4'b1111.
REQ-029 Reset mid-debounce or mid-hold abandons that press; a key held through reset shall be debounced anew from IDLE and accepted exactly once.

Verification (SCAN_DIV = 4, DEBOUNCE_SCANS = 2; scan = 16 cycles)
REQ-030 Reset for 2 cycles -> all outputs at REQ-028 values; col_n then cycles 1110, 1101, 1011, 0111, changing every 4 cycles.
REQ-031 Hold key 5 (row1,col1) for 10 scans -> exactly one key_valid, key_code = 5, digits = 32'h00000005, digit_count = 1.
REQ-032 Enter 1,2,3 -> digits = 32'h00000321, count 3; then A -> 32'h00000021, count 2; then C -> 32'h0, count 0.
REQ-033 Enter 1..8 then 9 -> digits = 32'h87654321, buf_full = 1 after the 8th; the 9th pulses key_valid with key_code = 9 and leaves digits unchanged.
REQ-034 Key 7 present for one scan only, and keys 1+6 pressed together for 10 scans -> no key_valid in either case.
REQ-035 Assert reset while key 3 is in DEBOUNCE, keep key held after reset release -> no pulse before reset; exactly one pulse with key_code = 3, 2 scans after reset release.
